// File: rtl/aes_round_ctrl_pkg.sv
// Shared definitions for the AES-128 round sequencer: default round count,
// select width, key-scheduler timeout, key width and FSM state encodings.
// Also consumed by the key scheduler and round datapath.
package aes_round_ctrl_pkg;

  localparam int AES_NR         = 10;
  localparam int AES_SEL_W      = 4;
  localparam int AES_KS_TIMEOUT = 256;
  localparam int AES_KEY_W      = 128;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYGEN = 3'd1,
    ST_SEL    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Round-key index for round r: forward cipher walks 0..nr, the equivalent
  // inverse cipher walks nr..0 over the same schedule.
  function automatic int key_sel(input int r, input int nr, input bit inv);
    return inv ? (nr - r) : r;
  endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// Saturating up-counter with synchronous clear. Used for the round index
// (terminal NR) and for the key-generation timeout (terminal KS_TIMEOUT-1).
// nxt is the value r will take at the next edge, so callers can register
// outputs that line up with the counter.
module aes_round_cnt #(
  parameter int W    = 4,
  parameter int TERM = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] r,
  output logic [W-1:0] nxt,
  output logic         last
);

  localparam logic [W-1:0] TERM_V = W'(TERM);

  assign last = (r == TERM_V);

  // Next count: clear wins, increment stops at the terminal value.
  always_comb begin
    nxt = r;
    if (clr) begin
      nxt = '0;
    end else if (inc && !last) begin
      nxt = r + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
    end else begin
      r <= nxt;
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 encryption round sequencer. Handles the Start/Done host handshake,
// the key scheduler En/Ry handshake with a timeout, and issues the per-round
// strobes (initial AddRoundKey, NR-1 full rounds, final round w/o MixColumns).
// All outputs are registered.
// Optional build macro: AES_DECRYPT_EN adds decrypt/inv_en and reverses the
// round-key select order for the equivalent inverse cipher.
//
//   state  | meaning
//   IDLE   | waiting for start; key_chg here invalidates keys directly
//   KEYGEN | ks_en high, waiting for ks_ry with timeout
//   SEL    | sel_key/round driven, key mux settling, no strobes
//   EXEC   | one round strobe (load / round / final round)
//   DONE   | one-cycle done pulse, err reported here on timeout
module aes_round_ctrl
  import aes_round_ctrl_pkg::*;
#(
  parameter int NR         = AES_NR,
  parameter int SEL_W      = AES_SEL_W,
  parameter int KS_TIMEOUT = AES_KS_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             key_chg,
  input  logic             ks_ry,
`ifdef AES_DECRYPT_EN
  input  logic             decrypt,
  output logic             inv_en,
`endif
  output logic             ks_en,
  output logic [SEL_W-1:0] sel_key,
  output logic             state_load,
  output logic             round_en,
  output logic             mix_en,
  output logic [SEL_W-1:0] round,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int TO_W = (KS_TIMEOUT > 2) ? $clog2(KS_TIMEOUT) : 1;
  localparam logic [SEL_W-1:0] NR_V = SEL_W'(NR);

  state_t state, state_nxt;

  logic             keys_valid, kv_nxt;
  logic             kc_pend, kc_nxt;
  logic             err_nxt;
  logic             inv_sel;

  logic             rnd_clr, rnd_inc, rnd_last;
  logic [SEL_W-1:0] rnd_r, rnd_nxt;
  logic             to_clr, to_inc, to_last;
  logic [TO_W-1:0]  to_r, to_nxt;

  logic             ks_en_nxt, state_load_nxt, round_en_nxt, mix_en_nxt;
  logic             busy_nxt, done_nxt;
  logic [SEL_W-1:0] sel_key_nxt, round_nxt;

  logic             unused_cnt;
  assign unused_cnt = ^{rnd_r, to_r, to_nxt};

  aes_round_cnt #(.W(SEL_W), .TERM(NR)) u_round_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (rnd_clr),
    .inc  (rnd_inc),
    .r    (rnd_r),
    .nxt  (rnd_nxt),
    .last (rnd_last)
  );

  aes_round_cnt #(.W(TO_W), .TERM(KS_TIMEOUT - 1)) u_timeout_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (to_clr),
    .inc  (to_inc),
    .r    (to_r),
    .nxt  (to_nxt),
    .last (to_last)
  );

`ifdef AES_DECRYPT_EN
  logic dec_q, dec_nxt;
  assign inv_sel = dec_nxt;
`else
  assign inv_sel = 1'b0;
`endif

  // Next-state, counter control and key-validity bookkeeping.
  always_comb begin
    state_nxt = state;
    kv_nxt    = keys_valid;
    kc_nxt    = kc_pend;
    err_nxt   = err;
    rnd_clr   = 1'b0;
    rnd_inc   = 1'b0;
    to_clr    = 1'b0;
    to_inc    = 1'b0;
`ifdef AES_DECRYPT_EN
    dec_nxt   = dec_q;
`endif

    // A key change during an operation is remembered, never aborts it.
    if (state != ST_IDLE && key_chg) begin
      kc_nxt = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (start) begin
          err_nxt = 1'b0;
          rnd_clr = 1'b1;
          to_clr  = 1'b1;
`ifdef AES_DECRYPT_EN
          dec_nxt = decrypt;
`endif
          if (keys_valid && !key_chg) begin
            state_nxt = ST_SEL;
          end else begin
            kv_nxt    = 1'b0;
            state_nxt = ST_KEYGEN;
          end
        end else if (key_chg) begin
          kv_nxt = 1'b0;
        end
      end
      ST_KEYGEN: begin
        if (ks_ry) begin
          kv_nxt    = 1'b1;
          state_nxt = ST_SEL;
        end else if (to_last) begin
          err_nxt   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          to_inc = 1'b1;
        end
      end
      ST_SEL: begin
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (rnd_last) begin
          state_nxt = ST_DONE;
        end else begin
          rnd_inc   = 1'b1;
          state_nxt = ST_SEL;
        end
      end
      ST_DONE: begin
        // Pending key change takes effect as we re-enter IDLE.
        if (kc_pend || key_chg) begin
          kv_nxt = 1'b0;
          kc_nxt = 1'b0;
        end
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state and round so outputs can be flopped.
  always_comb begin
    ks_en_nxt      = (state_nxt == ST_KEYGEN);
    busy_nxt       = (state_nxt != ST_IDLE);
    done_nxt       = (state_nxt == ST_DONE);
    sel_key_nxt    = '0;
    round_nxt      = '0;
    state_load_nxt = 1'b0;
    round_en_nxt   = 1'b0;
    mix_en_nxt     = 1'b0;
    if (state_nxt == ST_SEL || state_nxt == ST_EXEC) begin
      sel_key_nxt = SEL_W'(key_sel(int'(rnd_nxt), NR, inv_sel));
      round_nxt   = rnd_nxt;
    end
    if (state_nxt == ST_EXEC) begin
      if (rnd_nxt == '0) begin
        state_load_nxt = 1'b1;
      end else begin
        round_en_nxt = 1'b1;
        mix_en_nxt   = (rnd_nxt != NR_V);
      end
    end
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      keys_valid <= 1'b0;
      kc_pend    <= 1'b0;
      err        <= 1'b0;
      ks_en      <= 1'b0;
      sel_key    <= '0;
      state_load <= 1'b0;
      round_en   <= 1'b0;
      mix_en     <= 1'b0;
      round      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      keys_valid <= kv_nxt;
      kc_pend    <= kc_nxt;
      err        <= err_nxt;
      ks_en      <= ks_en_nxt;
      sel_key    <= sel_key_nxt;
      state_load <= state_load_nxt;
      round_en   <= round_en_nxt;
      mix_en     <= mix_en_nxt;
      round      <= round_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

`ifdef AES_DECRYPT_EN
  // Direction latched at start acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q <= 1'b0;
    end else begin
      dec_q <= dec_nxt;
    end
  end

  assign inv_en = dec_q;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: expected run summaries are queued when
// each run is started; a monitor accumulates per-run observations and pops
// and compares on every done pulse. Build with AES_DECRYPT_EN to add the
// inverse-order run.
module tb_aes_round_ctrl;

  localparam int SEL_W = 4;

  typedef struct {
    logic        err;
    int          busy;
    int          ksen;
    logic [43:0] sel;
    logic [10:0] ld;
    logic [10:0] ren;
    logic [10:0] mix;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, key_chg, ks_ry;
  logic ks_en, state_load, round_en, mix_en, busy, done, err;
  logic [SEL_W-1:0] sel_key, round;
`ifdef AES_DECRYPT_EN
  logic decrypt, inv_en;
`endif

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  aes_round_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_chg    (key_chg),
    .ks_ry      (ks_ry),
`ifdef AES_DECRYPT_EN
    .decrypt    (decrypt),
    .inv_en     (inv_en),
`endif
    .ks_en      (ks_en),
    .sel_key    (sel_key),
    .state_load (state_load),
    .round_en   (round_en),
    .mix_en     (mix_en),
    .round      (round),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] outs();
    logic [63:0] v;
    v = 64'({ks_en, sel_key, state_load, round_en, mix_en, round, busy, done, err});
`ifdef AES_DECRYPT_EN
    v = {v[62:0], inv_en};
`endif
    return v;
  endfunction

  // kind: 0 no rounds executed, 1 forward order, 2 inverse order
  function automatic exp_t mk(input logic e, input int b, input int k, input int kind);
    exp_t x;
    x.err  = e;
    x.busy = b;
    x.ksen = k;
    x.sel  = (kind == 1) ? 44'h0123456789A : (kind == 2) ? 44'hA9876543210 : 44'h0;
    x.ld   = (kind != 0) ? 11'h400 : 11'h0;
    x.ren  = (kind != 0) ? 11'h3FF : 11'h0;
    x.mix  = (kind != 0) ? 11'h3FE : 11'h0;
    return x;
  endfunction

  // Monitor: accumulate one run's observations, compare on done.
  initial begin
    logic        busy_q = 1'b0;
    logic        done_q = 1'b0;
    int          n_busy = 0;
    int          n_ks = 0;
    logic [43:0] sel_sig = '0;
    logic [10:0] ld_sig = '0, ren_sig = '0, mix_sig = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_q = 1'b0;
        done_q = 1'b0;
      end else begin
        if (busy && !busy_q) begin
          n_busy = 0; n_ks = 0; sel_sig = '0; ld_sig = '0; ren_sig = '0; mix_sig = '0;
        end
        if (busy) begin
          n_busy++;
          if (ks_en) n_ks++;
          if (state_load || round_en) begin
            sel_sig = {sel_sig[39:0], sel_key};
            ld_sig  = {ld_sig[9:0], state_load};
            ren_sig = {ren_sig[9:0], round_en};
            mix_sig = {mix_sig[9:0], mix_en};
          end
        end
        if (done_q) begin
          chk("done_single", 64'(done), 64'd0);
          chk("idle_after_done", 64'(busy), 64'd0);
        end
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("done_err", 64'(err), 64'(e.err));
            chk("busy_cycles", 64'(n_busy), 64'(e.busy));
            chk("ksen_cycles", 64'(n_ks), 64'(e.ksen));
            chk("sel_seq", 64'(sel_sig), 64'(e.sel));
            chk("load_seq", 64'(ld_sig), 64'(e.ld));
            chk("round_seq", 64'(ren_sig), 64'(e.ren));
            chk("mix_seq", 64'(mix_sig), 64'(e.mix));
          end
        end
        busy_q = busy;
        done_q = done;
      end
    end
  end

  task automatic start_pulse();
    @(negedge clk); #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int  n0;
    bit  got;
    n0  = done_cnt;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk); #1;
      if (done_cnt != n0) got = 1'b1;
    end
    chk(name, 64'(got), 64'd1);
  endtask

  task automatic wait_round(input int r, input bit need_en, input int budget, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk); #1;
      if (int'(round) == r && (!need_en || round_en)) got = 1'b1;
    end
    chk(name, 64'(got), 64'd1);
  endtask

  // Start with keys invalid, answer ks_ry after k key-generation cycles.
  task automatic keygen_run(input int k, input string name);
    start_pulse();
    chk(name, 64'(ks_en), 64'd1);
    repeat (k - 1) @(negedge clk);
    #1;
    ks_ry = 1'b1;
    @(negedge clk); #1;
    ks_ry = 1'b0;
    chk("ksen_drop", 64'(ks_en), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    rst = 1'b1; start = 1'b0; key_chg = 1'b0; ks_ry = 1'b0;
`ifdef AES_DECRYPT_EN
    decrypt = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", outs(), 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("idle_outputs", outs(), 64'd0);

    // First run: keys invalid, scheduler ready after 5 cycles.
    exp_q.push_back(mk(1'b0, 28, 5, 1));
    keygen_run(5, "ksen_first_start");
    chk("sel_key_first", 64'(sel_key), 64'd0);
    wait_done(40, "done_first");

    // Keys valid: straight to rounds, 23 busy cycles.
    exp_q.push_back(mk(1'b0, 23, 0, 1));
    start_pulse();
    chk("no_ksen_valid", 64'(ks_en), 64'd0);
    wait_done(40, "done_valid");

    // Start held high: ignored in DONE, accepted once back in IDLE.
    exp_q.push_back(mk(1'b0, 23, 0, 1));
    exp_q.push_back(mk(1'b0, 23, 0, 1));
    @(negedge clk); #1;
    start = 1'b1;
    wait_done(40, "done_b2b_first");
    @(negedge clk); #1;
    chk("b2b_idle_gap", 64'(busy), 64'd0);
    @(negedge clk); #1;
    chk("b2b_accept", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(40, "done_b2b_second");

    // Key change during round 4: run completes, next start regenerates keys.
    exp_q.push_back(mk(1'b0, 23, 0, 1));
    start_pulse();
    wait_round(4, 1'b0, 20, "reach_round4");
    key_chg = 1'b1;
    @(negedge clk); #1;
    key_chg = 1'b0;
    wait_done(40, "done_keychg_run");
    exp_q.push_back(mk(1'b0, 26, 3, 1));
    keygen_run(3, "keychg_regen");
    wait_done(40, "done_after_regen");

    // Invalidate keys in IDLE, then let the scheduler time out.
    @(negedge clk); #1;
    key_chg = 1'b1;
    @(negedge clk); #1;
    key_chg = 1'b0;
    exp_q.push_back(mk(1'b1, 257, 256, 0));
    start_pulse();
    wait_done(300, "done_timeout");
    @(negedge clk); #1;
    chk("err_held_idle", 64'(err), 64'd1);
    exp_q.push_back(mk(1'b0, 25, 2, 1));
    start_pulse();
    chk("err_cleared", 64'(err), 64'd0);
    chk("ksen_after_timeout", 64'(ks_en), 64'd1);
    @(negedge clk); #1;
    ks_ry = 1'b1;
    @(negedge clk); #1;
    ks_ry = 1'b0;
    wait_done(40, "done_after_timeout");

    // Reset during EXEC of round 6: no done, keys invalidated.
    start_pulse();
    wait_round(6, 1'b1, 20, "reach_exec6");
    saved = done_cnt;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_midrun_outputs", outs(), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_no_done", 64'(done_cnt), 64'(saved));
    exp_q.push_back(mk(1'b0, 25, 2, 1));
    keygen_run(2, "rst_clears_keys");
    wait_done(40, "done_after_rst");

`ifdef AES_DECRYPT_EN
    // Inverse cipher order with keys already valid.
    exp_q.push_back(mk(1'b0, 23, 0, 2));
    decrypt = 1'b1;
    start_pulse();
    decrypt = 1'b0;
    chk("inv_en_latched", 64'(inv_en), 64'd1);
    wait_done(40, "done_decrypt");
`endif

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
